// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Command-field layout and arbiter state encoding shared by the
//               SPI transaction arbiter and its round-robin picker.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int CMD_ID_MSB   = 13;
    localparam int CMD_ID_LSB   = 11;
    localparam int CMD_ADDR_MSB = 10;
    localparam int CMD_ADDR_LSB = 3;
    localparam int CMD_RD_BIT   = 1;

    localparam int GRANT_W = 3;

    localparam logic [1:0] C_ST_IDLE      = 2'd0;
    localparam logic [1:0] C_ST_WAIT_DONE = 2'd1;
    localparam logic [1:0] C_ST_DRAIN     = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = C_ST_IDLE,
        ST_WAIT_DONE = C_ST_WAIT_DONE,
        ST_DRAIN     = C_ST_DRAIN
    } arb_state_t;

    function automatic logic cmd_is_read(input logic [15:0] cmd);
        return cmd[CMD_RD_BIT];
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : spi_rr_pick
// Description : Combinational round-robin finder: first set request bit at or
//               above the pointer, wrapping modulo NREQ.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rr_pick
    import spi_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]    req,
    input  logic [GRANT_W-1:0] rr,
    output logic [GRANT_W-1:0] grant,
    output logic               any_valid
);

    logic [7:0] w_req8;
    logic [3:0] w_idx;

    assign w_req8 = 8'(req);

    // The pointer is always below NREQ, so one conditional subtract wraps it.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        w_idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = 4'(rr) + 4'(i);
            if (w_idx >= 4'(NREQ)) begin
                w_idx = w_idx - 4'(NREQ);
            end
            if (!any_valid && w_req8[w_idx[2:0]]) begin
                any_valid = 1'b1;
                grant     = w_idx[2:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_txn_arbiter
// Description : Round-robin arbiter sharing one SPI master between NREQ
//               requesters, with a per-transaction completion timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_txn_arbiter
    import spi_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4096,
    parameter int TW      = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_cmd,
    input  logic [16*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [15:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 m_start_tx,
    output logic [15:0]          m_cmd_packet,
    output logic [15:0]          m_data_out,
    input  logic                 m_spi_busy,
    input  logic                 m_tx_done,
    input  logic [15:0]          m_data_read,
    output logic [GRANT_W-1:0]   grant_idx,
    output logic                 arb_busy
);

    arb_state_t         r_state;
    logic [GRANT_W-1:0] r_rr;
    logic [TW-1:0]      r_cnt;

    logic [GRANT_W-1:0] w_grant;
    logic               w_any;
    logic [GRANT_W-1:0] w_rr_next;
    logic [15:0]        w_cmd   [8];
    logic [15:0]        w_wdata [8];

    // Padded to eight entries so a 3-bit index never leaves the array.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_unpack
            if (gi < NREQ) begin : g_live
                assign w_cmd[gi]   = req_cmd[gi*16 +: 16];
                assign w_wdata[gi] = req_wdata[gi*16 +: 16];
            end else begin : g_pad
                assign w_cmd[gi]   = 16'h0000;
                assign w_wdata[gi] = 16'h0000;
            end
        end
    endgenerate

    spi_rr_pick #(
        .NREQ      (NREQ)
    ) u_pick (
        .req       (req_valid),
        .rr        (r_rr),
        .grant     (w_grant),
        .any_valid (w_any)
    );

    assign w_rr_next = (grant_idx == GRANT_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rr         <= '0;
            r_cnt        <= '0;
            req_ready    <= '0;
            rsp_valid    <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            m_start_tx   <= 1'b0;
            m_cmd_packet <= '0;
            m_data_out   <= '0;
            grant_idx    <= '0;
            arb_busy     <= 1'b0;
        end else begin
            req_ready  <= '0;
            rsp_valid  <= '0;
            m_start_tx <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any && !m_spi_busy) begin
                        req_ready    <= NREQ'(1) << w_grant;
                        m_start_tx   <= 1'b1;
                        m_cmd_packet <= w_cmd[w_grant];
                        m_data_out   <= w_wdata[w_grant];
                        grant_idx    <= w_grant;
                        arb_busy     <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    // Completion is checked first so a coincident timeout loses.
                    if (m_tx_done) begin
                        rsp_valid <= NREQ'(1) << grant_idx;
                        rsp_rdata <= cmd_is_read(m_cmd_packet) ? m_data_read : 16'h0000;
                        rsp_err   <= 1'b0;
                        r_rr      <= w_rr_next;
                        arb_busy  <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (r_cnt == TW'(TIMEOUT - 1)) begin
                        rsp_valid <= NREQ'(1) << grant_idx;
                        rsp_rdata <= 16'h0000;
                        rsp_err   <= 1'b1;
                        r_rr      <= w_rr_next;
                        r_state   <= ST_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!m_spi_busy) begin
                        arb_busy <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
